// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, mode encoding, xtime and FSM state type
package aes_pkg;

    localparam logic [7:0] RED_POLY = 8'h1b;
    localparam logic       MODE_FWD = 1'b0;
    localparam logic       MODE_INV = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? RED_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/gf_mix_column.sv
// rtl/gf_mix_column.sv - combinational forward/inverse MixColumns on one 32-bit column
module gf_mix_column
    import aes_pkg::*;
(
    input  logic [31:0] col_in,
    input  logic        mode,
    output logic [31:0] col_out
);

    logic [7:0] a  [4];
    logic [7:0] m2 [4];
    logic [7:0] m4 [4];
    logic [7:0] m8 [4];
    logic [7:0] o  [4];
    logic [1:0] idx;

    always_comb begin
        idx = 2'd0;
        for (int j = 0; j < 4; j++) begin
            a[j]  = col_in[31 - 8*j -: 8];
            m2[j] = xtime(a[j]);
            m4[j] = xtime(m2[j]);
            m8[j] = xtime(m4[j]);
        end
        // Row r uses the base coefficient row rotated right by r.
        for (int r = 0; r < 4; r++) begin
            o[r] = 8'h00;
            for (int j = 0; j < 4; j++) begin
                idx = 2'(j - r);
                if (mode == MODE_INV) begin
                    case (idx)
                        2'd0:    o[r] = o[r] ^ m8[j] ^ m4[j] ^ m2[j];
                        2'd1:    o[r] = o[r] ^ m8[j] ^ m2[j] ^ a[j];
                        2'd2:    o[r] = o[r] ^ m8[j] ^ m4[j] ^ a[j];
                        default: o[r] = o[r] ^ m8[j] ^ a[j];
                    endcase
                end else begin
                    case (idx)
                        2'd0:    o[r] = o[r] ^ m2[j];
                        2'd1:    o[r] = o[r] ^ m2[j] ^ a[j];
                        default: o[r] = o[r] ^ a[j];
                    endcase
                end
            end
        end
        col_out = {o[0], o[1], o[2], o[3]};
    end

endmodule

// File: rtl/mix_columns_seq.sv
// rtl/mix_columns_seq.sv - sequential MixColumns over a 128-bit AES state, LANES columns per clock
module mix_columns_seq
    import aes_pkg::*;
#(
    parameter int LANES = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_mode,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
        $error("mix_columns_seq: LANES must be 1, 2 or 4");
    end

    localparam logic [1:0] LAST = 2'(4 / LANES - 1);

    state_e       state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         mode_q, mode_d;
    logic [127:0] work_q, work_d;
    logic [31:0]  lane_in  [LANES];
    logic [31:0]  lane_out [LANES];
    int           base;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        gf_mix_column u_col (
            .col_in  (lane_in[l]),
            .mode    (mode_q),
            .col_out (lane_out[l])
        );
    end

    always_comb begin
        base = (int'(cnt_q) * LANES) & 3;
        for (int l = 0; l < LANES; l++) begin
            lane_in[l] = work_q[127 - 32*(base + l) -: 32];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        work_d   = work_q;
        in_ready = 1'b0;
        case (state_q)
            ST_IDLE: in_ready = 1'b1;
            ST_RUN: begin
                for (int l = 0; l < LANES; l++) begin
                    work_d[127 - 32*(base + l) -: 32] = lane_out[l];
                end
                if (cnt_q == LAST) begin
                    cnt_d   = 2'd0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    in_ready = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Acceptance overrides the DONE->IDLE hop so back-to-back states see no bubble.
        if (in_valid && in_ready) begin
            work_d  = in_state;
            mode_d  = in_mode;
            cnt_d   = 2'd0;
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
            mode_q  <= MODE_FWD;
            work_q  <= 128'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            work_q  <= work_d;
        end
    end

    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign out_state = work_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// tb/tb_mix_columns_seq.sv - self-checking bench for mix_columns_seq at LANES 1, 2 and 4
module tb_mix_columns_seq;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid_a  [3];
    logic         in_ready_a  [3];
    logic         in_mode_a   [3];
    logic [127:0] in_state_a  [3];
    logic         out_valid_a [3];
    logic         out_ready_a [3];
    logic [127:0] out_state_a [3];
    logic         busy_a      [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = x;
        logic [7:0] bb = y;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] mix_state(input logic [127:0] s, input logic inv);
        logic [7:0]   fwd_row [4] = '{8'h02, 8'h03, 8'h01, 8'h01};
        logic [7:0]   inv_row [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        logic [127:0] r = '0;
        logic [7:0]   acc;
        logic [7:0]   coef;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    coef = inv ? inv_row[(j - row + 4) % 4] : fwd_row[(j - row + 4) % 4];
                    acc = acc ^ gmul(coef, s[127 - 32*c - 8*j -: 8]);
                end
                r[127 - 32*c - 8*row -: 8] = acc;
            end
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mix_columns_seq #(.LANES(1 << g)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid_a[g]),
            .in_ready  (in_ready_a[g]),
            .in_mode   (in_mode_a[g]),
            .in_state  (in_state_a[g]),
            .out_valid (out_valid_a[g]),
            .out_ready (out_ready_a[g]),
            .out_state (out_state_a[g]),
            .busy      (busy_a[g])
        );

        // Abstract model: a state is pending for 4/LANES edges, then offered until taken.
        logic         m_busy, m_valid;
        int           m_cnt;
        logic [127:0] m_pend, m_out;

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                m_busy = 0; m_valid = 0; m_cnt = 0; m_pend = '0; m_out = '0;
            end else if (!m_busy) begin
                if (in_valid_a[g]) begin
                    m_busy = 1; m_cnt = 4 >> g; m_pend = mix_state(in_state_a[g], in_mode_a[g]);
                end
            end else if (!m_valid) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_valid = 1; m_out = m_pend;
                end
            end else if (out_ready_a[g]) begin
                m_valid = 0; m_busy = 0;
                if (in_valid_a[g]) begin
                    m_busy = 1; m_cnt = 4 >> g; m_pend = mix_state(in_state_a[g], in_mode_a[g]);
                end
            end
        end

        always @(negedge clk) begin
            if (rst_n) begin
                chk($sformatf("L%0d in_ready", 1 << g), 128'(in_ready_a[g]),
                    128'(!m_busy || (m_valid && out_ready_a[g])));
                chk($sformatf("L%0d busy", 1 << g), 128'(busy_a[g]), 128'(m_busy));
                chk($sformatf("L%0d out_valid", 1 << g), 128'(out_valid_a[g]), 128'(m_valid));
                if (m_valid) chk($sformatf("L%0d out_state", 1 << g), out_state_a[g], m_out);
            end
        end
    end

    task automatic run_one(input int i, input logic [127:0] s, input logic m,
                           output logic [127:0] r, output int lat);
        @(posedge clk); #1;
        in_state_a[i] = s; in_mode_a[i] = m; in_valid_a[i] = 1'b1; out_ready_a[i] = 1'b1;
        @(posedge clk); #1;
        in_valid_a[i] = 1'b0;
        lat = 0;
        while (!out_valid_a[i] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        r = out_state_a[i];
    endtask

    localparam logic [127:0] VEC_A = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] VEC_B = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;

    initial begin
        logic [127:0] r, y, z, x, st;
        int lat;
        for (int i = 0; i < 3; i++) begin
            in_valid_a[i] = 0; in_mode_a[i] = 0; in_state_a[i] = '0; out_ready_a[i] = 0;
        end

        chk("model fwd literal", mix_state(VEC_A, 1'b0), VEC_B);
        chk("model inv literal", mix_state(VEC_B, 1'b1), VEC_A);

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset busy %0d", i), 128'(busy_a[i]), 128'd0);
            chk($sformatf("reset out_valid %0d", i), 128'(out_valid_a[i]), 128'd0);
            chk($sformatf("reset out_state %0d", i), out_state_a[i], 128'd0);
        end
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) chk($sformatf("post-reset in_ready %0d", i), 128'(in_ready_a[i]), 128'd1);

        run_one(0, VEC_A, 1'b0, r, lat);
        chk("L1 fwd result", r, VEC_B);
        chk("L1 fwd latency", 128'(lat), 128'd4);

        run_one(2, VEC_B, 1'b1, r, lat);
        chk("L4 inv result", r, VEC_A);
        chk("L4 inv latency", 128'(lat), 128'd1);

        // Back-to-back on LANES=2: inverse of the forward result enters in the DONE cycle.
        x = 128'h00112233_44556677_8899aabb_ccddeeff;
        y = mix_state(x, 1'b0);
        @(posedge clk); #1;
        in_state_a[1] = x; in_mode_a[1] = 0; in_valid_a[1] = 1; out_ready_a[1] = 1;
        @(posedge clk); #1;
        in_valid_a[1] = 0;
        repeat (2) begin @(posedge clk); #1; end
        chk("b2b first valid", 128'(out_valid_a[1]), 128'd1);
        chk("b2b first result", out_state_a[1], y);
        chk("b2b ready in done", 128'(in_ready_a[1]), 128'd1);
        in_state_a[1] = out_state_a[1]; in_mode_a[1] = 1; in_valid_a[1] = 1;
        @(posedge clk); #1;
        in_valid_a[1] = 0;
        chk("b2b no bubble busy", 128'(busy_a[1]), 128'd1);
        chk("b2b valid dropped", 128'(out_valid_a[1]), 128'd0);
        repeat (2) begin @(posedge clk); #1; end
        chk("b2b second valid", 128'(out_valid_a[1]), 128'd1);
        chk("b2b roundtrip", out_state_a[1], x);

        // Back-pressure in DONE while inputs churn during RUN.
        x = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
        @(posedge clk); #1;
        in_state_a[0] = x; in_mode_a[0] = 1; in_valid_a[0] = 1; out_ready_a[0] = 0;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            in_state_a[0] = {$urandom, $urandom, $urandom, $urandom};
            in_mode_a[0] = ~in_mode_a[0];
            @(posedge clk); #1;
        end
        in_valid_a[0] = 0;
        lat = 0;
        while (!out_valid_a[0] && lat < 20) begin @(posedge clk); #1; lat++; end
        st = out_state_a[0];
        chk("stall result", st, mix_state(x, 1'b1));
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            chk("stall valid held", 128'(out_valid_a[0]), 128'd1);
            chk("stall state held", out_state_a[0], st);
            chk("stall in_ready low", 128'(in_ready_a[0]), 128'd0);
        end
        out_ready_a[0] = 1;
        @(posedge clk); #1;
        chk("stall release", 128'(out_valid_a[0]), 128'd0);

        // Asynchronous reset mid-RUN.
        @(posedge clk); #1;
        in_state_a[0] = VEC_A; in_mode_a[0] = 0; in_valid_a[0] = 1;
        @(posedge clk); #1;
        in_valid_a[0] = 0;
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        chk("rst busy", 128'(busy_a[0]), 128'd0);
        chk("rst out_valid", 128'(out_valid_a[0]), 128'd0);
        @(posedge clk); #1;
        rst_n = 1;
        run_one(0, VEC_A, 1'b0, r, lat);
        chk("after rst result", r, VEC_B);

        for (int i = 0; i < 3; i++) begin
            for (int n = 0; n < 4; n++) begin
                x = {$urandom, $urandom, $urandom, $urandom};
                run_one(i, x, 1'b0, y, lat);
                chk($sformatf("rand fwd L%0d", 1 << i), y, mix_state(x, 1'b0));
                chk($sformatf("rand lat L%0d", 1 << i), 128'(lat), 128'(4 >> i));
                run_one(i, y, 1'b1, z, lat);
                chk($sformatf("rand inv(fwd) L%0d", 1 << i), z, x);
            end
        end

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
